// File: rtl/downscale_dma_if.sv
// Word-RAM bus between the downscale DMA (master) and the RAM/arbiter side (slave).
// The arbiter grants the bus through mem_gnt; read data returns one cycle after the address.
interface downscale_dma_if #(
    parameter int ADDR_W = 16
);
    logic              mem_gnt;
    logic              o_mem_we;
    logic [3:0]        o_mem_byte_en;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;

    modport master (
        input  mem_gnt, i_mem_rdata,
        output o_mem_we, o_mem_byte_en, o_mem_addr, o_mem_wdata
    );

    modport slave (
        output mem_gnt, i_mem_rdata,
        input  o_mem_we, o_mem_byte_en, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/downscale_dma.sv
// Reads an 8-bit grayscale image from word RAM (4 px/word), box-averages each 2x2 block
// and writes the half-size image back, one output word per four source-word reads.
module downscale_dma #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]  src_wwords,
    input  logic [DIM_W-1:0]  src_rows,
    output logic              busy,
    output logic              done,
    downscale_dma_if.master   mem
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, DRAIN, WR, DONE} state_e;

    state_e            state_q;
    logic              busy_q, done_q, we_q, pend_q;
    logic [3:0]        be_q;
    logic [1:0]        slot_q;
    logic [ADDR_W-1:0] addr_q, row_ptr_q, col_off_q, stride_q, dst_ptr_q;
    logic [31:0]       wdata_q;
    logic [DIM_W-1:0]  w_q, h_q, col_q, row_q;
    logic [3:0][31:0]  d_q, d_d;

    logic [DIM_W-1:0]  w_d, h_d;
    logic [ADDR_W-1:0] stride_d, row_ptr_d, col_off_d;
    logic              last_col, last_row;

    function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
        logic [9:0] s;
        s = 10'(a) + 10'(b) + 10'(c) + 10'(d) + 10'd2;
        return 8'(s >> 2);
    endfunction

    // d[0]/d[1] are the top row's two words, d[2]/d[3] the bottom row's.
    function automatic logic [31:0] downscale_word(input logic [3:0][31:0] d);
        logic [63:0] top, bot;
        logic [31:0] r;
        top = {d[1], d[0]};
        bot = {d[3], d[2]};
        for (int j = 0; j < 4; j++)
            r[8*j +: 8] = avg4(top[16*j +: 8], top[16*j+8 +: 8], bot[16*j +: 8], bot[16*j+8 +: 8]);
        return r;
    endfunction

    always_comb begin
        d_d = d_q;
        if (pend_q)
            d_d[slot_q] = mem.i_mem_rdata;
    end

    assign w_d       = src_wwords & ~DIM_W'(1);
    assign h_d       = src_rows & ~DIM_W'(1);
    assign stride_d  = ADDR_W'({w_d, 2'b00});
    assign last_col  = (col_q + DIM_W'(1)) == (w_q >> 1);
    assign last_row  = (row_q + DIM_W'(2)) == h_q;
    assign row_ptr_d = last_col ? row_ptr_q + (stride_q << 1) : row_ptr_q;
    assign col_off_d = last_col ? '0 : col_off_q + ADDR_W'(8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'h0;
            addr_q    <= '0;
            wdata_q   <= '0;
            row_ptr_q <= '0;
            col_off_q <= '0;
            stride_q  <= '0;
            dst_ptr_q <= '0;
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            pend_q    <= 1'b0;
            slot_q    <= 2'd0;
            d_q       <= '0;
        end else begin
            done_q <= 1'b0;
            pend_q <= 1'b0;
            d_q    <= d_d;
            case (state_q)
                IDLE: if (start) begin
                    busy_q    <= 1'b1;
                    w_q       <= w_d;
                    h_q       <= h_d;
                    stride_q  <= stride_d;
                    dst_ptr_q <= dst_base;
                    row_ptr_q <= src_base;
                    col_off_q <= '0;
                    col_q     <= '0;
                    row_q     <= '0;
                    if (w_d == '0 || h_d == '0) begin
                        state_q <= DONE;
                    end else begin
                        addr_q  <= src_base;
                        state_q <= RD0;
                    end
                end
                RD0: if (mem.mem_gnt) begin
                    pend_q  <= 1'b1;
                    slot_q  <= 2'd0;
                    addr_q  <= addr_q + ADDR_W'(4);
                    state_q <= RD1;
                end
                RD1: if (mem.mem_gnt) begin
                    pend_q  <= 1'b1;
                    slot_q  <= 2'd1;
                    addr_q  <= row_ptr_q + stride_q + col_off_q;
                    state_q <= RD2;
                end
                RD2: if (mem.mem_gnt) begin
                    pend_q  <= 1'b1;
                    slot_q  <= 2'd2;
                    addr_q  <= addr_q + ADDR_W'(4);
                    state_q <= RD3;
                end
                RD3: if (mem.mem_gnt) begin
                    pend_q  <= 1'b1;
                    slot_q  <= 2'd3;
                    state_q <= DRAIN;
                end
                // The last read word arrives this cycle and feeds the average directly.
                DRAIN: begin
                    we_q    <= 1'b1;
                    be_q    <= 4'hF;
                    addr_q  <= dst_ptr_q;
                    wdata_q <= downscale_word(d_d);
                    state_q <= WR;
                end
                WR: if (mem.mem_gnt) begin
                    we_q      <= 1'b0;
                    be_q      <= 4'h0;
                    dst_ptr_q <= dst_ptr_q + ADDR_W'(4);
                    row_ptr_q <= row_ptr_d;
                    col_off_q <= col_off_d;
                    col_q     <= last_col ? '0 : col_q + DIM_W'(1);
                    row_q     <= last_col ? row_q + DIM_W'(2) : row_q;
                    if (last_col && last_row) begin
                        state_q <= DONE;
                    end else begin
                        addr_q  <= row_ptr_d + col_off_d;
                        state_q <= RD0;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign mem.o_mem_we      = we_q;
    assign mem.o_mem_byte_en = be_q;
    assign mem.o_mem_addr    = addr_q;
    assign mem.o_mem_wdata   = wdata_q;
endmodule

// File: tb/tb_downscale_dma.sv
// Bench for downscale_dma: a 1-cycle-latency word RAM model, a write scoreboard
// and one task per scenario.
module tb_downscale_dma;
    localparam int ADDR_W = 16;
    localparam int DIM_W  = 10;
    localparam logic [ADDR_W-1:0] SRC = 16'h0100;
    localparam logic [ADDR_W-1:0] DST = 16'h0800;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic [DIM_W-1:0]  src_wwords = '0;
    logic [DIM_W-1:0]  src_rows = '0;
    logic              busy, done;

    downscale_dma_if #(.ADDR_W(ADDR_W)) bus ();

    downscale_dma #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .src_wwords (src_wwords),
        .src_rows   (src_rows),
        .busy       (busy),
        .done       (done),
        .mem        (bus)
    );

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] ram [0:1023];
    logic [47:0] exp_q[$];
    logic [47:0] obs_q[$];

    always #5 clk = ~clk;

    // RAM: address sampled at the edge, data returned during the next cycle.
    always @(posedge clk) begin
        bus.i_mem_rdata <= ram[bus.o_mem_addr[11:2]];
        if (rst_n && bus.mem_gnt && bus.o_mem_we)
            obs_q.push_back({bus.o_mem_addr, bus.o_mem_wdata});
    end

    task automatic load_t1();
        ram[64] = 32'h04030201;
        ram[65] = 32'h08070605;
        ram[66] = 32'h0C0B0A09;
        ram[67] = 32'h100F0E0D;
    endtask

    task automatic start_job(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                             input logic [DIM_W-1:0] w, input logic [DIM_W-1:0] h);
        @(negedge clk);
        src_base   = s;
        dst_base   = d;
        src_wwords = w;
        src_rows   = h;
        start      = 1'b1;
    endtask

    // n = clock edges from the one that samples start until done is seen (-1 on timeout).
    task automatic run_to_done(input int repulse_at, output int n, output bit saw_busy);
        n = -1;
        saw_busy = 1'b0;
        for (int i = 1; i <= 500; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                start = 1'b0;
                saw_busy = busy;
            end
            if (i == repulse_at) begin
                start      = 1'b1;
                src_base   = 16'h0000;
                dst_base   = 16'h0C00;
                src_wwords = 10'd8;
                src_rows   = 10'd8;
            end
            if (i == repulse_at + 1) start = 1'b0;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({busy, done} !== 2'b00) begin
            nerr++; $display("FAIL reset_busy_done: got %b, expected 00", {busy, done});
        end
        nvec++;
        if ({bus.o_mem_we, bus.o_mem_byte_en} !== 5'h00) begin
            nerr++; $display("FAIL reset_we_be: got %h, expected 00", {bus.o_mem_we, bus.o_mem_byte_en});
        end
        nvec++;
        if ({bus.o_mem_addr, bus.o_mem_wdata} !== 48'h0) begin
            nerr++; $display("FAIL reset_addr_wdata: got %h, expected 0", {bus.o_mem_addr, bus.o_mem_wdata});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int n; bit b;
        load_t1();
        obs_q.delete();
        exp_q.push_back({DST, 32'h0C0A0806});
        start_job(SRC, DST, 10'd2, 10'd2);
        run_to_done(0, n, b);
        nvec++;
        if (b !== 1'b1) begin nerr++; $display("FAIL basic_busy: got %b, expected 1", b); end
        // RD0 is entered on edge 1; done appears 7 edges later.
        nvec++;
        if (n !== 8) begin nerr++; $display("FAIL basic_latency: got %0d, expected 8", n); end
        @(posedge clk); #1;
        nvec++;
        if (done !== 1'b0) begin nerr++; $display("FAIL basic_done_pulse: got %b, expected 0", done); end
        nvec++;
        if (obs_q.size() !== exp_q.size()) begin
            nerr++; $display("FAIL basic_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            nvec++;
            if (obs_q[k] !== exp_q[k]) begin
                nerr++; $display("FAIL basic_write[%0d]: got addr_data %h, expected %h", k, obs_q[k], exp_q[k]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturate();
        int n; bit b;
        for (int i = 0; i < 16; i++) ram[64 + i] = 32'hFFFFFFFF;
        obs_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({DST + 16'(4 * i), 32'hFFFFFFFF});
        start_job(SRC, DST, 10'd4, 10'd4);
        run_to_done(0, n, b);
        nvec++;
        if (n !== 26) begin nerr++; $display("FAIL sat_latency: got %0d, expected 26", n); end
        nvec++;
        if (obs_q.size() !== exp_q.size()) begin
            nerr++; $display("FAIL sat_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            nvec++;
            if (obs_q[k] !== exp_q[k]) begin
                nerr++; $display("FAIL sat_write[%0d]: got addr_data %h, expected %h", k, obs_q[k], exp_q[k]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    // Blocks: s=5 -> 1, s=6 -> 2, s=1 -> 0, s=1019 -> 255.
    task automatic test_rounding();
        int n; bit b;
        ram[64] = 32'h01010101;
        ram[65] = 32'hFFFF0000;
        ram[66] = 32'h02020201;
        ram[67] = 32'hFEFF0100;
        obs_q.delete();
        exp_q.push_back({DST, 32'hFF000201});
        start_job(SRC, DST, 10'd2, 10'd2);
        run_to_done(0, n, b);
        nvec++;
        if (obs_q.size() !== exp_q.size()) begin
            nerr++; $display("FAIL round_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            nvec++;
            if (obs_q[k] !== exp_q[k]) begin
                nerr++; $display("FAIL round_write[%0d]: got addr_data %h, expected %h", k, obs_q[k], exp_q[k]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    function automatic int px(input int row, input int col, input int wwords);
        logic [31:0] w;
        w = ram[64 + row * wwords + col / 4];
        return int'(w[8 * (col % 4) +: 8]);
    endfunction

    task automatic test_random();
        int n; bit b; int s;
        logic [31:0] word;
        for (int i = 0; i < 24; i++) ram[64 + i] = $urandom;
        obs_q.delete();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++) begin
                for (int j = 0; j < 4; j++) begin
                    s = px(2*r, 8*c + 2*j, 6) + px(2*r, 8*c + 2*j + 1, 6)
                      + px(2*r + 1, 8*c + 2*j, 6) + px(2*r + 1, 8*c + 2*j + 1, 6);
                    word[8*j +: 8] = 8'((s + 2) / 4);
                end
                exp_q.push_back({DST + 16'(4 * (r * 3 + c)), word});
            end
        start_job(SRC, DST, 10'd7, 10'd5);
        run_to_done(0, n, b);
        nvec++;
        if (n !== 38) begin nerr++; $display("FAIL rand_latency: got %0d, expected 38", n); end
        nvec++;
        if (obs_q.size() !== exp_q.size()) begin
            nerr++; $display("FAIL rand_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            nvec++;
            if (obs_q[k] !== exp_q[k]) begin
                nerr++; $display("FAIL rand_write[%0d]: got addr_data %h, expected %h", k, obs_q[k], exp_q[k]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_gnt_stall();
        int n = -1; int stall_left = 0; int stalls = 0;
        bit held = 1'b1;
        logic [ADDR_W-1:0] hold_addr = '0;
        logic hold_we = 1'b0;
        load_t1();
        obs_q.delete();
        exp_q.push_back({DST, 32'h0C0A0806});
        start_job(SRC, DST, 10'd2, 10'd2);
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (done) begin n = i; break; end
            if (stall_left > 0) begin
                if (bus.o_mem_addr !== hold_addr || bus.o_mem_we !== hold_we) held = 1'b0;
                stall_left--;
                if (stall_left == 0) bus.mem_gnt = 1'b1;
            end else if (stalls == 0 && bus.o_mem_addr == SRC + 16'd8 && bus.o_mem_we == 1'b0) begin
                bus.mem_gnt = 1'b0; hold_addr = bus.o_mem_addr; hold_we = 1'b0;
                stall_left = 5; stalls++;
            end else if (stalls == 1 && bus.o_mem_we == 1'b1) begin
                bus.mem_gnt = 1'b0; hold_addr = bus.o_mem_addr; hold_we = 1'b1;
                stall_left = 5; stalls++;
            end
        end
        bus.mem_gnt = 1'b1;
        nvec++;
        if (stalls !== 2) begin nerr++; $display("FAIL stall_phases: got %0d, expected 2", stalls); end
        nvec++;
        if (held !== 1'b1) begin nerr++; $display("FAIL stall_hold: got %b, expected 1", held); end
        nvec++;
        if (n !== 18) begin nerr++; $display("FAIL stall_latency: got %0d, expected 18", n); end
        nvec++;
        if (obs_q.size() !== exp_q.size()) begin
            nerr++; $display("FAIL stall_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            nvec++;
            if (obs_q[k] !== exp_q[k]) begin
                nerr++; $display("FAIL stall_write[%0d]: got addr_data %h, expected %h", k, obs_q[k], exp_q[k]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_degenerate();
        int n; bit b;
        obs_q.delete();
        start_job(SRC, DST, 10'd1, 10'd4);
        run_to_done(0, n, b);
        nvec++;
        if ({b, 8'(n)} !== {1'b1, 8'd2}) begin
            nerr++; $display("FAIL deg_w0: got busy %b latency %0d, expected busy 1 latency 2", b, n);
        end
        start_job(SRC, DST, 10'd4, 10'd1);
        run_to_done(0, n, b);
        nvec++;
        if (n !== 2) begin nerr++; $display("FAIL deg_h1_latency: got %0d, expected 2", n); end
        nvec++;
        if (obs_q.size() !== 0) begin
            nerr++; $display("FAIL deg_writes: got %0d writes, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_busy_start();
        int n; bit b;
        load_t1();
        obs_q.delete();
        exp_q.push_back({DST, 32'h0C0A0806});
        start_job(SRC, DST, 10'd2, 10'd2);
        run_to_done(3, n, b);
        nvec++;
        if (n !== 8) begin nerr++; $display("FAIL busy_start_latency: got %0d, expected 8", n); end
        repeat (12) @(posedge clk);
        #1;
        nvec++;
        if (busy !== 1'b0) begin nerr++; $display("FAIL busy_start_idle: got %b, expected 0", busy); end
        nvec++;
        if (obs_q.size() !== exp_q.size()) begin
            nerr++; $display("FAIL busy_start_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            nvec++;
            if (obs_q[k] !== exp_q[k]) begin
                nerr++; $display("FAIL busy_start_write[%0d]: got addr_data %h, expected %h", k, obs_q[k], exp_q[k]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_midjob();
        int n; bit b; bit in_wr = 1'b0;
        load_t1();
        obs_q.delete();
        start_job(SRC, DST, 10'd2, 10'd2);
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (i == 1) start = 1'b0;
            if (bus.o_mem_we) begin in_wr = 1'b1; break; end
        end
        bus.mem_gnt = 1'b0;
        nvec++;
        if (in_wr !== 1'b1) begin nerr++; $display("FAIL rst_reach_wr: got %b, expected 1", in_wr); end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({busy, done, bus.o_mem_we, bus.o_mem_byte_en} !== 7'h00) begin
            nerr++; $display("FAIL rst_ctrl: got %h, expected 00", {busy, done, bus.o_mem_we, bus.o_mem_byte_en});
        end
        nvec++;
        if ({bus.o_mem_addr, bus.o_mem_wdata} !== 48'h0) begin
            nerr++; $display("FAIL rst_bus: got %h, expected 0", {bus.o_mem_addr, bus.o_mem_wdata});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.mem_gnt = 1'b1;
        nvec++;
        if (obs_q.size() !== 0) begin nerr++; $display("FAIL rst_writes: got %0d, expected 0", obs_q.size()); end
        obs_q.delete();
        exp_q.push_back({DST, 32'h0C0A0806});
        start_job(SRC, DST, 10'd2, 10'd2);
        run_to_done(0, n, b);
        nvec++;
        if (n !== 8) begin nerr++; $display("FAIL rst_rerun_latency: got %0d, expected 8", n); end
        nvec++;
        if (obs_q.size() !== exp_q.size()) begin
            nerr++; $display("FAIL rst_rerun_count: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[k]) if (k < obs_q.size()) begin
            nvec++;
            if (obs_q[k] !== exp_q[k]) begin
                nerr++; $display("FAIL rst_rerun_write[%0d]: got addr_data %h, expected %h", k, obs_q[k], exp_q[k]);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        bus.mem_gnt = 1'b1;
        test_reset();
        test_basic();
        test_saturate();
        test_rounding();
        test_random();
        test_gnt_stall();
        test_degenerate();
        test_busy_start();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
